// File: rtl/bn_serial_alu.sv
// Multi-cycle N-bit ALU: W bits per clock, LSB first, through one shared W-bit adder slice.
// Valid/ready on both sides; result and flags are registered and held until taken.
module bn_serial_alu #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         overflow
);

  localparam int unsigned Beats = N / W;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpNor  = 3'b100;
  localparam logic [2:0] OpSltu = 3'b101;
  localparam logic [2:0] OpSub  = 3'b110;
  localparam logic [2:0] OpSlt  = 3'b111;

  if (N < 2 || W == 0 || (N % W) != 0) begin : g_bad_params
    $error("bn_serial_alu: need N >= 2 and W dividing N");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [2:0]      op_q;
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    acc_q;

  logic [W-1:0]    slice_a;
  logic [W-1:0]    slice_b;
  logic [W-1:0]    slice_sum;
  logic [W-1:0]    slice_res;
  logic            slice_cout;
  logic            slice_cin_msb;
  logic            chain;
  logic [N+W-1:0]  acc_cat;
  logic [N-1:0]    acc_next;
  logic            ovf;
  logic            lt;
  logic [N-1:0]    final_res;
  logic            final_carry;
  logic            final_ovf;
  logic            in_sub;

  // SUB, SLT and SLTU all run a + ~b + 1 through the adder.
  assign in_sub   = (op == OpSub) || (op == OpSlt) || (op == OpSltu);
  assign in_ready = (state_q == StIdle);

  assign slice_a = a_q[W-1:0];
  assign slice_b = b_q[W-1:0];

  always_comb begin
    chain         = carry_q;
    slice_cin_msb = 1'b0;
    slice_sum     = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i == W - 1) slice_cin_msb = chain;
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain;
      chain        = (slice_a[i] & slice_b[i]) | (chain & (slice_a[i] ^ slice_b[i]));
    end
    slice_cout = chain;
  end

  always_comb begin
    unique case (op_q)
      OpAnd:   slice_res = slice_a & slice_b;
      OpOr:    slice_res = slice_a | slice_b;
      OpXor:   slice_res = slice_a ^ slice_b;
      OpNor:   slice_res = ~(slice_a | slice_b);
      default: slice_res = slice_sum;
    endcase
  end

  // New bits enter from the MSB side; after the last beat acc_next holds the full word.
  assign acc_cat  = {slice_res, acc_q};
  assign acc_next = acc_cat[N+W-1:W];

  // Only meaningful on the final beat, where the slice holds the word's MSB.
  assign ovf = slice_cin_msb ^ slice_cout;

  always_comb begin
    lt          = 1'b0;
    final_res   = acc_next;
    final_carry = 1'b0;
    final_ovf   = 1'b0;
    unique case (op_q)
      OpAdd, OpSub: begin
        final_carry = slice_cout;
        final_ovf   = ovf;
      end
      OpSlt: begin
        lt          = slice_sum[W-1] ^ ovf;
        final_res   = {{(N-1){1'b0}}, lt};
        final_carry = slice_cout;
      end
      OpSltu: begin
        lt          = ~slice_cout;
        final_res   = {{(N-1){1'b0}}, lt};
        final_carry = slice_cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OpAnd;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= in_sub ? ~b : b;
            op_q    <= op;
            carry_q <= in_sub;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          a_q     <= a_q >> W;
          b_q     <= b_q >> W;
          carry_q <= slice_cout;
          acc_q   <= acc_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            result    <= final_res;
            zero      <= (final_res == '0);
            carry     <= final_carry;
            overflow  <= final_ovf;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
